am_mod: RTL

//  Transmit-side AM modulator: the inverse of the AM envelope detector.

---
 rtl/am_mod_pkg.sv | 41 ++++
 rtl/am_mod_nco.sv | 80 ++++++++
 rtl/am_mod.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/am_mod_pkg.sv
// am_mod_pkg: constants and helpers shared by the AM modulator.
// Macro AM_MOD_CLIP_CNT_EN enables the clip counter in am_mod.
package am_mod_pkg;

  localparam int AM_WIDTH       = 16;
  localparam int AM_PHASE_WIDTH = 32;
  localparam int AM_LUT_ADDR    = 10;
  localparam int AM_DEPTH_WIDTH = 8;
  localparam int CLIP_CNT_W     = 16;

  localparam real AM_PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Unmodulated envelope level: half of full scale.
  function automatic int carrier_of(int width);
    return 1 << (width - 2);
  endfunction

  localparam int CARRIER_LEVEL = carrier_of(AM_WIDTH);

  // Clamp the envelope into [0, hi].
  function automatic int env_clamp(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Quarter-wave entry k, sampled half a step off the grid.
  function automatic int rom_entry(int k, int lut_addr, int peak);
    real x;
    x = (real'(k) + 0.5) * AM_PI / real'(1 << (lut_addr + 1));
    return $rtoi(real'(peak) * $sin(x) + 0.5);
  endfunction

endpackage

// File: rtl/am_mod_nco.sv
// am_mod_nco: sample-rate phase accumulator and quarter-wave sine ROM.
// cos/sin come out registered two cycles after the accepted sample.
module am_mod_nco
  import am_mod_pkg::*;
#(
  parameter int WIDTH       = AM_WIDTH,
  parameter int PHASE_WIDTH = AM_PHASE_WIDTH,
  parameter int LUT_ADDR    = AM_LUT_ADDR
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic                    i_valid,
  input  logic [PHASE_WIDTH-1:0]  i_freq_word,
  output logic signed [WIDTH-1:0] o_cos,
  output logic signed [WIDTH-1:0] o_sin
);

  localparam int N    = 1 << LUT_ADDR;
  localparam int PEAK = (1 << (WIDTH - 1)) - 1;

  logic [PHASE_WIDTH-1:0] r_phase;
  quad_e                  r_quad;
  logic [LUT_ADDR-1:0]    r_idx;

  logic [WIDTH-2:0]        w_rom [N];
  logic [WIDTH-2:0]        w_smag;
  logic [WIDTH-2:0]        w_cmag;
  logic signed [WIDTH-1:0] w_sp;
  logic signed [WIDTH-1:0] w_cp;
  logic signed [WIDTH-1:0] w_cos;
  logic signed [WIDTH-1:0] w_sin;

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam int V = rom_entry(k, LUT_ADDR, PEAK);
    assign w_rom[k] = (WIDTH-1)'(V);
  end

  // Quadrant boundaries are exact: sin term is forced to zero there.
  assign w_smag = (r_idx == '0) ? '0 : w_rom[r_idx];
  assign w_cmag = w_rom[~r_idx];
  assign w_sp   = {1'b0, w_smag};
  assign w_cp   = {1'b0, w_cmag};

  // Sample the phase address, then step the accumulator.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_phase <= '0;
      r_quad  <= Q0;
      r_idx   <= '0;
    end else if (i_valid) begin
      r_quad  <= quad_e'(r_phase[PHASE_WIDTH-1 -: 2]);
      r_idx   <= r_phase[PHASE_WIDTH-3 -: LUT_ADDR];
      r_phase <= r_phase + i_freq_word;
    end
  end

  // Mirror and negate the quarter wave by quadrant.
  always_comb begin
    w_cos = w_cp;
    w_sin = w_sp;
    unique case (r_quad)
      Q0: begin w_cos = w_cp;  w_sin = w_sp;  end
      Q1: begin w_cos = -w_sp; w_sin = w_cp;  end
      Q2: begin w_cos = -w_cp; w_sin = -w_sp; end
      Q3: begin w_cos = w_sp;  w_sin = -w_cp; end
    endcase
  end

  // Register the mapped cos/sin.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      o_cos <= '0;
      o_sin <= '0;
    end else begin
      o_cos <= w_cos;
      o_sin <= w_sin;
    end
  end

endmodule

// File: rtl/am_mod.sv
// am_mod: audio to AM envelope, mixed with a sample-rate NCO into I/Q.
// Macro AM_MOD_CLIP_CNT_EN adds clip_count_clr / clip_count.
module am_mod
  import am_mod_pkg::*;
#(
  parameter int WIDTH       = AM_WIDTH,
  parameter int PHASE_WIDTH = AM_PHASE_WIDTH,
  parameter int LUT_ADDR    = AM_LUT_ADDR,
  parameter int DEPTH_WIDTH = AM_DEPTH_WIDTH
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic [PHASE_WIDTH-1:0]  freq_word,
  input  logic [DEPTH_WIDTH-1:0]  depth,
  input  logic                    enable,
`ifdef AM_MOD_CLIP_CNT_EN
  input  logic                    clip_count_clr,
  output logic [CLIP_CNT_W-1:0]   clip_count,
`endif
  output logic                    mod_valid,
  output logic signed [WIDTH-1:0] i_out,
  output logic signed [WIDTH-1:0] q_out,
  output logic                    clip
);

  localparam int PW      = WIDTH + DEPTH_WIDTH + 1;
  localparam int ENV_MAX = (1 << (WIDTH - 1)) - 1;
  localparam int CARRIER = carrier_of(WIDTH);

  logic                      r_v1;
  logic                      r_v2;
  logic                      r_v3;
  logic signed [PW-1:0]      r_prod;
  logic                      r_en1;
  logic signed [WIDTH-1:0]   r_env;
  logic                      r_clip2;
  logic                      r_clip3;
  logic signed [2*WIDTH-1:0] r_ip;
  logic signed [2*WIDTH-1:0] r_qp;

  logic signed [WIDTH-1:0] w_cos;
  logic signed [WIDTH-1:0] w_sin;
  logic signed [PW-1:0]    w_term;
  logic signed [31:0]      w_sum;

  am_mod_nco #(
    .WIDTH       (WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .LUT_ADDR    (LUT_ADDR)
  ) u_nco (
    .clock          (clock),
    .clock_areset_n (clock_areset_n),
    .i_valid        (in_valid),
    .i_freq_word    (freq_word),
    .o_cos          (w_cos),
    .o_sin          (w_sin)
  );

  assign w_term = r_prod >>> DEPTH_WIDTH;
  assign w_sum  = CARRIER + 32'(w_term);

  // Valid pipe; reset drops every in-flight sample.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      mod_valid <= 1'b0;
    end else begin
      r_v1      <= in_valid;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      mod_valid <= r_v3;
    end
  end

  // S1: audio times unsigned depth.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_prod <= '0;
      r_en1  <= 1'b0;
    end else if (in_valid) begin
      r_prod <= PW'(audio_in) * PW'($signed({1'b0, depth}));
      r_en1  <= enable;
    end
  end

  // S2: add carrier and clamp; carrier off forces zero.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_env   <= '0;
      r_clip2 <= 1'b0;
    end else if (r_v1) begin
      r_env   <= r_en1 ? WIDTH'(env_clamp(w_sum, ENV_MAX)) : '0;
      r_clip2 <= r_en1 && (w_sum < 0 || w_sum > ENV_MAX);
    end
  end

  // S3: envelope times cos/sin.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_ip    <= '0;
      r_qp    <= '0;
      r_clip3 <= 1'b0;
    end else if (r_v2) begin
      r_ip    <= (2*WIDTH)'(r_env) * (2*WIDTH)'(w_cos);
      r_qp    <= (2*WIDTH)'(r_env) * (2*WIDTH)'(w_sin);
      r_clip3 <= r_clip2;
    end
  end

  // S4: floor-scale to WIDTH; hold I/Q between samples.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      i_out <= '0;
      q_out <= '0;
      clip  <= 1'b0;
    end else begin
      clip <= r_v3 & r_clip3;
      if (r_v3) begin
        i_out <= WIDTH'(r_ip >>> (WIDTH - 1));
        q_out <= WIDTH'(r_qp >>> (WIDTH - 1));
      end
    end
  end

`ifdef AM_MOD_CLIP_CNT_EN
  logic [CLIP_CNT_W-1:0] r_clip_cnt;

  // Saturating count of clipped output samples; clear wins.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      r_clip_cnt <= '0;
    end else if (clip_count_clr) begin
      r_clip_cnt <= '0;
    end else if (mod_valid && clip && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 1'b1;
    end
  end

  assign clip_count = r_clip_cnt;
`endif

endmodule
